// File: rtl/comparador_credito_pkg.sv
// Shared definitions for the vending-machine payment path: controller state
// codes, coin encoding and cent values, and the payment-stage state encoding.
package pacote_maquina;

  // Main controller state codes as seen on `estados`
  localparam logic [1:0] ESPERA     = 2'b00;
  localparam logic [1:0] PRODUTO    = 2'b01;
  localparam logic [1:0] COMPARADOR = 2'b10;

  // Coin codes, shared by inserted coins and change coins
  localparam logic [1:0] MOEDA_5  = 2'b00;
  localparam logic [1:0] MOEDA_10 = 2'b01;
  localparam logic [1:0] MOEDA_25 = 2'b10;
  localparam logic [1:0] MOEDA_50 = 2'b11;

  localparam int unsigned VALOR_5  = 5;
  localparam int unsigned VALOR_10 = 10;
  localparam int unsigned VALOR_25 = 25;
  localparam int unsigned VALOR_50 = 50;

  // Payment-stage states
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    ACUMULA = 2'b01,
    TROCO   = 2'b10,
    FIM     = 2'b11
  } estado_t;

  // Cent value of a coin code (7 bits is enough for 50)
  function automatic logic [6:0] valor_moeda(input logic [1:0] codigo);
    logic [6:0] v;
    case (codigo)
      MOEDA_5:  v = 7'(VALOR_5);
      MOEDA_10: v = 7'(VALOR_10);
      MOEDA_25: v = 7'(VALOR_25);
      default:  v = 7'(VALOR_50);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/comparador_credito_if.sv
// Payment-stage bus: controller/coin-acceptor/dispenser side is the master,
// the payment stage is the slave.
import pacote_maquina::*;

interface comparador_credito_if #(
  parameter int LARGURA = 8
);
  logic [1:0]         estados;
  logic [LARGURA-1:0] preco;
  logic               moeda_valida;
  logic [1:0]         moeda_codigo;
  logic               cancelar;
  logic               troco_pronto;
  logic               troco_valido;
  logic [1:0]         troco_codigo;
  logic               OK;
  logic               vender;
  logic               moeda_rejeitada;
  logic [LARGURA-1:0] credito;

  modport master (
    output estados, preco, moeda_valida, moeda_codigo, cancelar, troco_pronto,
    input  troco_valido, troco_codigo, OK, vender, moeda_rejeitada, credito
  );

  modport slave (
    input  estados, preco, moeda_valida, moeda_codigo, cancelar, troco_pronto,
    output troco_valido, troco_codigo, OK, vender, moeda_rejeitada, credito
  );
endinterface

// File: rtl/comparador_credito_seletor_troco.sv
// Greedy change selector: largest coin not exceeding the remaining change.
import pacote_maquina::*;

module seletor_troco #(
  parameter int LARGURA = 8
) (
  input  logic [LARGURA:0] troco,
  output logic             valido,
  output logic [1:0]       codigo,
  output logic [LARGURA:0] valor
);
  localparam int W = LARGURA + 1;
  localparam logic [W-1:0] V5  = W'(VALOR_5);
  localparam logic [W-1:0] V10 = W'(VALOR_10);
  localparam logic [W-1:0] V25 = W'(VALOR_25);
  localparam logic [W-1:0] V50 = W'(VALOR_50);

  // Pick the biggest coin that fits; nothing when less than 5 cents remain
  always_comb begin
    valido = 1'b1;
    codigo = MOEDA_5;
    if (troco >= V50)      codigo = MOEDA_50;
    else if (troco >= V25) codigo = MOEDA_25;
    else if (troco >= V10) codigo = MOEDA_10;
    else if (troco >= V5)  codigo = MOEDA_5;
    else                   valido = 1'b0;
    valor = valido ? W'(valor_moeda(codigo)) : '0;
  end
endmodule

// File: rtl/comparador_credito.sv
// comparador_credito: payment stage of the vending-machine controller.
// Latches the price when the controller enters COMPARADOR, accumulates coins,
// pays change one coin at a time, then pulses OK (with vender on a sale).
// Optional: define TIMEOUT_EN to auto-cancel after TIMEOUT idle cycles in ACUMULA.
import pacote_maquina::*;

module comparador_credito #(
  parameter int LARGURA = 8,
  parameter int TIMEOUT = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  comparador_credito_if.slave bus
);
  // One extra bit so credit/change never wrap inside the stage
  localparam int W = LARGURA + 1;
  localparam logic [W-1:0] CINCO = W'(VALOR_5);

  estado_t            estado, estado_nxt;
  logic [W-1:0]       credito_q, credito_nxt;
  logic [W-1:0]       troco_q, troco_nxt;
  logic [LARGURA-1:0] preco_q, preco_nxt;
  logic               cancel_q, cancel_nxt;
  logic [W-1:0]       moeda_val;
  logic               expira;

  logic               troco_valido_q;
  logic [1:0]         troco_codigo_q;
  logic [W-1:0]       troco_valor_q;
  logic               ok_q, vender_q, rejeitada_q;
  logic [LARGURA-1:0] credito_out_q;

  logic               sel_valido;
  logic [1:0]         sel_codigo;
  logic [W-1:0]       sel_valor;

  if (TIMEOUT < 1) begin : g_timeout_invalido
    $error("comparador_credito: TIMEOUT must be at least 1");
  end

  assign moeda_val = W'(valor_moeda(bus.moeda_codigo));

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] ocioso_cnt;

  assign expira = (estado == ACUMULA) && !bus.moeda_valida &&
                  (ocioso_cnt == CW'(TIMEOUT - 1));

  // Idle-cycle counter: zero outside ACUMULA and on every coin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ocioso_cnt <= '0;
    else if (estado != ACUMULA || bus.moeda_valida) ocioso_cnt <= '0;
    else if (!expira)                             ocioso_cnt <= ocioso_cnt + 1'b1;
  end
`else
  assign expira = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    estado_nxt  = estado;
    credito_nxt = credito_q;
    troco_nxt   = troco_q;
    preco_nxt   = preco_q;
    cancel_nxt  = cancel_q;
    case (estado)
      OCIOSO: begin
        credito_nxt = '0;
        if (bus.estados == COMPARADOR) begin
          preco_nxt  = bus.preco;
          cancel_nxt = 1'b0;
          estado_nxt = ACUMULA;
        end
      end
      ACUMULA: begin
        if (bus.moeda_valida) credito_nxt = credito_q + moeda_val;
        // A coin landing on the decision cycle is folded into the change
        if (credito_q >= {1'b0, preco_q}) begin
          troco_nxt  = credito_nxt - {1'b0, preco_q};
          estado_nxt = TROCO;
        end else if (bus.cancelar || expira) begin
          troco_nxt  = credito_nxt;
          cancel_nxt = 1'b1;
          estado_nxt = TROCO;
        end
      end
      TROCO: begin
        // Sub-5c residue is dropped
        if (troco_q < CINCO)
          estado_nxt = FIM;
        else if (troco_valido_q && bus.troco_pronto)
          troco_nxt = troco_q - troco_valor_q;
      end
      default: begin
        credito_nxt = '0;
        estado_nxt  = OCIOSO;
      end
    endcase
  end

  // Selector looks at next change so a new coin follows a handshake directly
  seletor_troco #(.LARGURA(LARGURA)) u_seletor (
    .troco  (troco_nxt),
    .valido (sel_valido),
    .codigo (sel_codigo),
    .valor  (sel_valor)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      credito_q <= '0;
      troco_q   <= '0;
      preco_q   <= '0;
      cancel_q  <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      credito_q <= credito_nxt;
      troco_q   <= troco_nxt;
      preco_q   <= preco_nxt;
      cancel_q  <= cancel_nxt;
    end
  end

  // Registered outputs, derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      troco_valido_q <= 1'b0;
      troco_codigo_q <= '0;
      troco_valor_q  <= '0;
      ok_q           <= 1'b0;
      vender_q       <= 1'b0;
      rejeitada_q    <= 1'b0;
      credito_out_q  <= '0;
    end else begin
      troco_valido_q <= (estado_nxt == TROCO) && sel_valido;
      troco_codigo_q <= ((estado_nxt == TROCO) && sel_valido) ? sel_codigo : '0;
      troco_valor_q  <= ((estado_nxt == TROCO) && sel_valido) ? sel_valor : '0;
      ok_q           <= (estado_nxt == FIM);
      vender_q       <= (estado_nxt == FIM) && !cancel_q;
      rejeitada_q    <= bus.moeda_valida && (estado != ACUMULA);
      credito_out_q  <= credito_nxt[LARGURA] ? {LARGURA{1'b1}} : credito_nxt[LARGURA-1:0];
    end
  end

  assign bus.troco_valido    = troco_valido_q;
  assign bus.troco_codigo    = troco_codigo_q;
  assign bus.OK              = ok_q;
  assign bus.vender          = vender_q;
  assign bus.moeda_rejeitada = rejeitada_q;
  assign bus.credito         = credito_out_q;

endmodule

// File: tb/tb_comparador_credito.sv
// Scoreboard bench for comparador_credito: expected change coins and
// vender values are queued as stimulus is driven and popped as the DUT
// hands out coins / pulses OK.
module tb_comparador_credito;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [1:0] exp_coins[$];
  logic       exp_vender[$];

  comparador_credito_if #(.LARGURA(8)) bus ();

  comparador_credito #(.LARGURA(8), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_chk++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Dispenser/controller monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.troco_valido && bus.troco_pronto) begin
        if (exp_coins.size() == 0) chk("coin_extra", {30'd0, bus.troco_codigo}, 32'hFFFF_FFFF);
        else chk("coin_code", {30'd0, bus.troco_codigo}, {30'd0, exp_coins.pop_front()});
      end
      if (bus.OK) begin
        chk("ok_after_change", exp_coins.size(), 0);
        if (exp_vender.size() == 0) chk("ok_extra", {31'd0, bus.vender}, 2);
        else chk("vender", {31'd0, bus.vender}, {31'd0, exp_vender.pop_front()});
      end
    end
  end

  task automatic start(input logic [7:0] p);
    @(posedge clk); #1;
    bus.estados = 2'b10;
    bus.preco   = p;
  endtask

  task automatic coin(input logic [1:0] c, input logic canc);
    @(posedge clk); #1;
    bus.moeda_valida = 1'b1;
    bus.moeda_codigo = c;
    bus.cancelar     = canc;
    @(posedge clk); #1;
    bus.moeda_valida = 1'b0;
    bus.cancelar     = 1'b0;
  endtask

  task automatic chk_credito(input string tag, input int v);
    @(negedge clk);
    chk(tag, {24'd0, bus.credito}, v);
  endtask

  task automatic wait_done();
    int seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.OK) begin
        seen = 1;
        bus.estados = 2'b00;
      end
    end
    chk("ok_seen", seen, 1);
    @(negedge clk);
    chk("ok_one_cycle", {31'd0, bus.OK}, 0);
  endtask

  task automatic wait_valid();
    int seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.troco_valido) seen = 1;
    end
    chk("valid_seen", seen, 1);
  endtask

  initial begin
    bus.estados = 2'b00; bus.preco = '0; bus.moeda_valida = 1'b0; bus.moeda_codigo = 2'b00;
    bus.cancelar = 1'b0; bus.troco_pronto = 1'b1;
    #2;
    chk("rst_valid",  {31'd0, bus.troco_valido}, 0);
    chk("rst_code",   {30'd0, bus.troco_codigo}, 0);
    chk("rst_ok",     {31'd0, bus.OK}, 0);
    chk("rst_vender", {31'd0, bus.vender}, 0);
    chk("rst_rej",    {31'd0, bus.moeda_rejeitada}, 0);
    chk("rst_cred",   {24'd0, bus.credito}, 0);
    #20 rst_n = 1'b1;

    // Sale with 5c change: 25+10 for 30
    exp_coins.push_back(2'b00); exp_vender.push_back(1'b1);
    start(8'd30);
    coin(2'b10, 1'b0); chk_credito("cred_25", 25);
    coin(2'b01, 1'b0); chk_credito("cred_35", 35);
    wait_done();

    // Price reached before a late cancel: sale wins
    exp_coins.push_back(2'b01); exp_vender.push_back(1'b1);
    start(8'd40);
    coin(2'b11, 1'b0); chk_credito("cred_50", 50);
    bus.cancelar = 1'b1;
    @(posedge clk); #1 bus.cancelar = 1'b0;
    wait_done();

    // Coin with cancel on the same cycle: coin refunded
    exp_coins.push_back(2'b10); exp_vender.push_back(1'b0);
    start(8'd100);
    coin(2'b10, 1'b1); chk_credito("cred_refund", 25);
    wait_done();

    // Refund of 80 with the dispenser stalled; coin strobe during change
    bus.troco_pronto = 1'b0;
    exp_coins.push_back(2'b11); exp_coins.push_back(2'b10); exp_coins.push_back(2'b00);
    exp_vender.push_back(1'b0);
    start(8'd200);
    coin(2'b11, 1'b0);
    coin(2'b10, 1'b0);
    coin(2'b00, 1'b0); chk_credito("cred_80", 80);
    bus.cancelar = 1'b1;
    @(posedge clk); #1 bus.cancelar = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_code",  {30'd0, bus.troco_codigo}, 3);
      chk("hold_valid", {31'd0, bus.troco_valido}, 1);
      if (i == 1) begin bus.moeda_valida = 1'b1; bus.moeda_codigo = 2'b10; end
      if (i == 2) begin chk("rej_troco", {31'd0, bus.moeda_rejeitada}, 1); bus.moeda_valida = 1'b0; end
      if (i == 4) chk("cred_troco", {24'd0, bus.credito}, 80);
      else @(negedge clk);
    end
    @(posedge clk); #1 bus.troco_pronto = 1'b1;
    wait_done();

    // Coin strobe while idle
    @(negedge clk); bus.moeda_valida = 1'b1; bus.moeda_codigo = 2'b11;
    @(negedge clk);
    chk("rej_idle", {31'd0, bus.moeda_rejeitada}, 1);
    chk("cred_idle", {24'd0, bus.credito}, 0);
    bus.moeda_valida = 1'b0;
    @(negedge clk);
    chk("rej_pulse", {31'd0, bus.moeda_rejeitada}, 0);

    // Zero price: immediate finish, no change
    exp_vender.push_back(1'b1);
    start(8'd0);
    wait_done();

    // Non-multiple-of-5 price: 17c change pays 10+5, 2c dropped
    exp_coins.push_back(2'b01); exp_coins.push_back(2'b00); exp_vender.push_back(1'b1);
    start(8'd33);
    coin(2'b11, 1'b0);
    wait_done();

    // Display saturation: 6x50 against 255, change 45 = 25+10+10
    exp_coins.push_back(2'b10); exp_coins.push_back(2'b01); exp_coins.push_back(2'b01);
    exp_vender.push_back(1'b1);
    start(8'd255);
    for (int k = 1; k <= 6; k++) begin
      coin(2'b11, 1'b0);
      chk_credito("cred_sat", (50 * k > 255) ? 255 : 50 * k);
    end
    wait_done();

`ifdef TIMEOUT_EN
    // Idle timeout acts as cancel
    exp_coins.push_back(2'b01); exp_vender.push_back(1'b0);
    start(8'd100);
    coin(2'b01, 1'b0); chk_credito("cred_to", 10);
    wait_done();
`endif

    // Async reset while change is being presented
    bus.troco_pronto = 1'b0;
    start(8'd200);
    coin(2'b11, 1'b0);
    bus.cancelar = 1'b1;
    @(posedge clk); #1 bus.cancelar = 1'b0;
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.troco_valido}, 0);
    chk("arst_code",  {30'd0, bus.troco_codigo}, 0);
    chk("arst_cred",  {24'd0, bus.credito}, 0);
    chk("arst_ok",    {31'd0, bus.OK}, 0);
    bus.troco_pronto = 1'b1;
    bus.estados = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {31'd0, bus.troco_valido}, 0);
    chk("post_rst_cred",  {24'd0, bus.credito}, 0);
    chk("queues_drained", exp_coins.size() + exp_vender.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
